// File: rtl/sseg_scan.sv
// =============================================================================
// Module   : sseg_scan
// Brief    : Frame-latched scan driver for a 4-digit common-anode 7-seg display
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module sseg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [7:0]  sseg,
    output logic [3:0]  en_dig,
    output logic        frame_tick
);

    localparam int                 CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   C_BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       idx_q,   idx_d;
    logic [15:0]      value_s_q;
    logic [3:0]       dp_s_q;
    logic [3:0]       blank_s_q;
    logic [7:0]       sseg_q,  sseg_d;
    logic [3:0]       en_q,    en_d;
    logic             tick_q,  tick_d;
    logic             load;
    logic [3:0]       nibble;

    // Active-high {g,f,e,d,c,b,a} glyphs for hex digits.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

    always_comb begin
        load = (cnt_q == '0) && (idx_q == 2'd0);
        if (cnt_q == C_CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Outputs use the shadow copy only; the shadow changes while the
    // blank window is active, so no digit ever shows a mixed frame.
    always_comb begin
        nibble = value_s_q[{idx_q, 2'b00} +: 4];
        tick_d = load;
        if (cnt_q < C_BLANK_END) begin
            en_d   = 4'hF;
            sseg_d = 8'hFF;
        end else if (blank_s_q[idx_q]) begin
            en_d   = ~(4'b0001 << idx_q);
            sseg_d = 8'hFF;
        end else begin
            en_d   = ~(4'b0001 << idx_q);
            sseg_d = {~dp_s_q[idx_q], ~font(nibble)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            value_s_q <= 16'h0000;
            dp_s_q    <= 4'h0;
            blank_s_q <= 4'h0;
            sseg_q    <= 8'hFF;
            en_q      <= 4'hF;
            tick_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sseg_q <= sseg_d;
            en_q   <= en_d;
            tick_q <= tick_d;
            if (load) begin
                value_s_q <= value;
                dp_s_q    <= dp;
                blank_s_q <= blank;
            end
        end
    end

    assign sseg       = sseg_q;
    assign en_dig     = en_q;
    assign frame_tick = tick_q;

endmodule

`default_nettype wire
